// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared FSM states and 3x3 window index constants for the LBP engine
package lbp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BORDER,
    S_FETCH,
    S_LAST,
    S_WRITE,
    S_DONE
  } lbp_state_e;

  // Window slot k holds sample (row-1 + k%3, col-1 + k/3): column-major, oldest column first.
  localparam int WIN_N       = 9;
  localparam int CENTRE_IDX  = 4;
  localparam int FETCH_FULL  = 0;
  localparam int FETCH_SHIFT = 6;
  localparam int FETCH_END   = 8;

  // Window slot feeding each output bit b0..b7.
  localparam int NB_IDX [8] = '{0, 3, 6, 1, 7, 2, 5, 8};

endpackage

// File: rtl/lbp_code.sv
// rtl/lbp_code.sv - combinational 8-neighbour LBP comparison over a flattened 3x3 window
module lbp_code
  import lbp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [WIN_N*DATA_W-1:0] win,
  input  logic                    mode,
  input  logic [DATA_W-1:0]       thr,
  output logic [7:0]              code
);

  logic [DATA_W:0] ref_v;

  // One extra bit so centre+thr never wraps below a bright neighbour.
  always_comb begin
    ref_v = {1'b0, win[CENTRE_IDX*DATA_W +: DATA_W]} + (mode ? {1'b0, thr} : '0);
    code  = '0;
    for (int b = 0; b < 8; b++) begin
      code[b] = ({1'b0, win[NB_IDX[b]*DATA_W +: DATA_W]} >= ref_v);
    end
  end

endmodule

// File: rtl/lbp_window_engine.sv
// rtl/lbp_window_engine.sv - raster-scan LBP engine: reads a gray frame, writes one code per pixel
module lbp_window_engine
  import lbp_pkg::*;
#(
  parameter  int IMG_W  = 128,
  parameter  int IMG_H  = 128,
  parameter  int DATA_W = 8,
  localparam int COL_W  = $clog2(IMG_W),
  localparam int ROW_W  = $clog2(IMG_H),
  localparam int ADDR_W = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  input  logic              mode,
  input  logic [DATA_W-1:0] thr,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  lbp_state_e              state, state_nx;
  logic [ROW_W-1:0]        row, nx_row, f_row;
  logic [COL_W-1:0]        col, nx_col, f_col;
  logic [3:0]              fcnt, pend_idx;
  logic                    pend_valid;
  logic                    mode_r;
  logic [DATA_W-1:0]       thr_r;
  logic [DATA_W-1:0]       win [WIN_N];
  logic [WIN_N*DATA_W-1:0] win_flat;
  logic [ADDR_W-1:0]       addr_hold;
  logic [7:0]              code;
  logic                    last_col, last_row, is_last, nx_border;

  always_comb begin
    last_col  = (col == COL_W'(IMG_W - 1));
    last_row  = (row == ROW_W'(IMG_H - 1));
    is_last   = last_col && last_row;
    nx_col    = last_col ? '0 : col + COL_W'(1);
    nx_row    = last_col ? row + ROW_W'(1) : row;
    nx_border = (nx_row == '0) || (nx_row == ROW_W'(IMG_H - 1)) ||
                (nx_col == '0) || (nx_col == COL_W'(IMG_W - 1));
    f_row     = row + ROW_W'(fcnt % 4'd3) - ROW_W'(1);
    f_col     = col + COL_W'(fcnt / 4'd3) - COL_W'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:           if (gray_ready) state_nx = S_BORDER;
      S_BORDER,
      S_WRITE:          state_nx = is_last ? S_DONE : (nx_border ? S_BORDER : S_FETCH);
      S_FETCH:          if (fcnt == 4'(FETCH_END)) state_nx = S_LAST;
      S_LAST:           state_nx = S_WRITE;
      S_DONE:           state_nx = S_DONE;
      default:          state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      fcnt       <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      mode_r     <= 1'b0;
      thr_r      <= '0;
      addr_hold  <= '0;
      for (int i = 0; i < WIN_N; i++) win[i] <= '0;
    end else begin
      state      <= state_nx;
      // Read data lands one cycle after its request; remember which slot it belongs to.
      pend_valid <= (state == S_FETCH);
      pend_idx   <= fcnt;
      if (pend_valid) win[pend_idx] <= gray_data;
      case (state)
        S_IDLE: if (gray_ready) begin
          mode_r <= mode;
          thr_r  <= thr;
        end
        S_BORDER, S_WRITE: if (!is_last) begin
          row <= nx_row;
          col <= nx_col;
          if (!nx_border) begin
            if (nx_col == COL_W'(1)) begin
              fcnt <= 4'(FETCH_FULL);
            end else begin
              fcnt <= 4'(FETCH_SHIFT);
              for (int i = 0; i < 6; i++) win[i] <= win[i+3];
            end
          end
        end
        S_FETCH: begin
          addr_hold <= {f_row, f_col};
          if (fcnt != 4'(FETCH_END)) fcnt <= fcnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < WIN_N; i++) win_flat[i*DATA_W +: DATA_W] = win[i];
  end

  lbp_code #(.DATA_W(DATA_W)) u_code (
    .win  (win_flat),
    .mode (mode_r),
    .thr  (thr_r),
    .code (code)
  );

  assign gray_req  = (state == S_FETCH);
  assign gray_addr = gray_req ? {f_row, f_col} : addr_hold;
  assign lbp_valid = (state == S_BORDER) || (state == S_WRITE);
  assign lbp_addr  = {row, col};
  assign lbp_data  = (state == S_WRITE) ? code : 8'h00;
  assign finish    = (state == S_DONE);

endmodule

// File: tb/tb_lbp_window_engine.sv
// tb/tb_lbp_window_engine.sv - scoreboard bench for lbp_window_engine on an 8x4 frame
module tb_lbp_window_engine;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int CW = 3;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data = '0;
  logic          mode;
  logic [DW-1:0] thr;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  logic [7:0] img [H][W];
  wr_t        exp_q [$];
  wr_t        obs_q [$];
  wr_t        ref_q [$];
  int         rd_cnt  = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  lbp_window_engine #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .mode       (mode),
    .thr        (thr),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gray_req) begin
      gray_data <= img[gray_addr[AW-1:CW]][gray_addr[CW-1:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && lbp_valid === 1'b1) begin
      wr_t e;
      obs_q.push_back('{addr: lbp_addr, data: lbp_data});
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(lbp_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(lbp_addr), 32'(e.addr));
        check("wr_data", 32'(lbp_data), 32'(e.data));
      end
    end
  end

  function automatic logic [7:0] model_code(int r, int c, bit m, int t);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] code = '0;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
    for (int b = 0; b < 8; b++)
      if (int'(img[r+dr[b]][c+dc[b]]) >= int'(img[r][c]) + (m ? t : 0)) code[b] = 1'b1;
    return code;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_gray_req"},  32'(gray_req),  0);
    check({tag, "_gray_addr"}, 32'(gray_addr), 0);
    check({tag, "_lbp_valid"}, 32'(lbp_valid), 0);
    check({tag, "_lbp_addr"},  32'(lbp_addr),  0);
    check({tag, "_lbp_data"},  32'(lbp_data),  0);
    check({tag, "_finish"},    32'(finish),    0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    gray_ready = 1'b0;
    exp_q.delete();
    #1 check_zero("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_frame(input bit m, input logic [7:0] t);
    @(negedge clk);
    mode = m;
    thr  = t;
    obs_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back('{addr: AW'(r * W + c), data: model_code(r, c, m, int'(t))});
    gray_ready = 1'b1;
  endtask

  task automatic run_frame(input bit m, input logic [7:0] t, input string tag, input bit do_reset);
    int cyc = 0;
    int rd0;
    int exp_cyc = 1 + 2 * W + 2 * (H - 2) + (H - 2) * (11 + 5 * (W - 3));
    int exp_rd  = (H - 2) * (9 + 3 * (W - 3));
    if (do_reset) pulse_reset();
    rd0 = rd_cnt;
    start_frame(m, t);
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      mode = 1'($urandom);
      thr  = 8'($urandom);
      if (finish) break;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_pending"}, 32'(exp_q.size()), 0);
    check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    for (int i = 0; i < 3; i++) begin
      gray_ready = 1'(i);
      @(negedge clk);
      check({tag, "_done_finish"}, 32'(finish), 1);
      check({tag, "_done_req"}, 32'(gray_req), 0);
    end
    gray_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    gray_ready = 1'b0;
    mode = 1'b0;
    thr = '0;
    foreach (img[r, c]) img[r][c] = 8'd64;
    repeat (3) @(negedge clk);
    check_zero("por");
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_gray_req", 32'(gray_req), 0);
      check("idle_lbp_valid", 32'(lbp_valid), 0);
      check("idle_finish", 32'(finish), 0);
    end

    run_frame(1'b0, 8'd0, "flat_m0", 1'b1);
    run_frame(1'b1, 8'd1, "flat_m1_t1", 1'b1);
    run_frame(1'b1, 8'd0, "flat_m1_t0", 1'b1);

    foreach (img[r, c]) img[r][c] = 8'(c);
    run_frame(1'b0, 8'd0, "ramp", 1'b1);

    foreach (img[r, c]) img[r][c] = 8'd255;
    img[1][3] = 8'd250;
    img[2][5] = 8'd250;
    run_frame(1'b1, 8'd10, "sat", 1'b1);

    for (int k = 0; k < 4; k++) begin
      foreach (img[r, c]) img[r][c] = (k[0]) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      run_frame(1'($urandom), 8'($urandom_range(0, 4)), "rand", 1'b1);
    end

    foreach (img[r, c]) img[r][c] = 8'($urandom_range(0, 7));
    run_frame(1'b1, 8'd2, "ref", 1'b1);
    ref_q = obs_q;

    pulse_reset();
    start_frame(1'b1, 8'd2);
    begin
      int n = 0;
      while (n < 2000 && !(lbp_valid && lbp_addr[AW-1:CW] == 2'd2)) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach_row2", 32'(n < 2000), 1);
    end
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    #1 check_zero("abort");
    @(negedge clk);
    gray_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle_valid", 32'(lbp_valid), 0);
    run_frame(1'b1, 8'd2, "rerun", 1'b0);
    check("rerun_len", 32'(obs_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
      check("rerun_addr", 32'(obs_q[i].addr), 32'(ref_q[i].addr));
      check("rerun_data", 32'(obs_q[i].data), 32'(ref_q[i].data));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lbp_window_engine.md
LBP_WINDOW_ENGINE -- requirements
Module: lbp_window_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 128, meaning image width in pixels (power of two, >=4).
REQ-002 SHALL have parameter IMG_H, default 128, meaning image height in pixels (power of two, >=4).
REQ-003 SHALL have parameter DATA_W, default 8, meaning gray sample width; ADDR_W = log2(IMG_H)+log2(IMG_W), derived, not overridable.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: gray_ready  in  1  image available/start; gray_req  out  1  read strobe; gray_addr  out  ADDR_W  read address {row,col}; gray_data  in  DATA_W  read data.
REQ-006 SHALL have ports: mode  in  1  0=basic LBP, 1=thresholded LBP; thr  in  DATA_W  threshold for mode 1.
REQ-007 SHALL have ports: lbp_valid  out  1  write strobe; lbp_addr  out  ADDR_W  write address {row,col}; lbp_data  out  8  LBP code; finish  out  1  frame done.

Function
REQ-008 SHALL sample gray_data one cycle after a cycle with gray_req=1 and gray_addr driven; no back-pressure.
REQ-009 SHALL implement FSM states IDLE, BORDER, FETCH, LAST, WRITE, DONE.
REQ-010 IDLE SHALL leave on the first cycle gray_ready=1, capturing mode and thr; both held constant for the frame.
REQ-011 SHALL visit pixels in raster order (row-major, col fastest) and write every address exactly once.
REQ-012 Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) SHALL be written in BORDER with lbp_data=0, one pixel per cycle, no reads.
REQ-013 First interior pixel of a row SHALL fetch all 9 window samples (9 FETCH cycles); subsequent interior pixels SHALL shift the window left and fetch only the 3 right-column samples (3 FETCH cycles).
REQ-014 FETCH order within a column SHALL be row-1, row, row+1; LAST captures the final sample with gray_req=0.
REQ-015 WRITE SHALL assert lbp_valid for exactly one cycle with lbp_addr={row,col}; lbp_valid=0 in all other states.
REQ-016 Bit order SHALL be: b0 (r-1,c-1), b1 (r-1,c), b2 (r-1,c+1), b3 (r,c-1), b4 (r,c+1), b5 (r+1,c-1), b6 (r+1,c), b7 (r+1,c+1).
REQ-017 Mode 0: bit = neighbour >= centre. Mode 1: bit = neighbour >= centre+thr, sum computed in DATA_W+1 bits (no wrap).
REQ-018 Interior steady-state throughput SHALL be 5 cycles/pixel (3 FETCH + LAST + WRITE); row-start pixel 11 cycles.
REQ-019 After the write of (IMG_H-1, IMG_W-1) the FSM SHALL enter DONE; finish=1 from that cycle until reset; gray_ready ignored in DONE.
REQ-020 gray_req SHALL be 1 only in FETCH; gray_addr holds its last value otherwise.

Reset
REQ-021 reset=0 SHALL immediately force state IDLE, row=col=0, gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0, window registers=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame; after release the block restarts from (0,0) on the next gray_ready=1.

Structure
REQ-023 Shared package lbp_pkg SHALL hold the FSM state enumeration and the neighbour bit-index constants.
REQ-024 Comparison SHALL be a sub-module lbp_code (9 samples, mode, thr in; 8-bit code out), combinational.

Verification
REQ-025 IMG_W=8, IMG_H=4, constant image 64, mode 0 -> 32 writes in raster order, interior (1..2,1..6) = 0xFF, border = 0x00, finish=1 after last.
REQ-026 Same image, mode 1, thr=1 -> interior = 0x00; thr=0 -> 0xFF.
REQ-027 Pixel value = col (horizontal ramp), mode 0 -> interior code 0xD6 (b1,b2,b4,b6,b7 set).
REQ-028 Centre 250, neighbours 255, mode 1, thr=10 -> code 0x00 (no overflow wrap).
REQ-029 gray_ready held 0 for 20 cycles -> gray_req=0, lbp_valid=0, finish=0 throughout.
REQ-030 reset pulsed low during row 2 -> all outputs 0 within the same cycle; full frame rerun produces identical output sequence.
